// File: rtl/sequential_alu.sv
// sequential_alu -- multi-cycle ALU with a three-state control FSM.
//
// Single-cycle operations (AND, OR, NOR, ADD, SUB, LUI, compare, invalid)
// complete on the accepting edge. SLL and SRL with a non-zero shift amount
// shift a work register by one bit per cycle.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous active-low reset
//   start        request pulse, accepted only when busy=0
//   ALUOperation 4-bit opcode (0 AND,1 OR,2 NOR,3 ADD,4 SUB,5 LUI,6 SLL,
//                7 SRL,8 compare, 9-15 invalid)
//   A, B         32-bit operands
//   shamt        5-bit shift amount for SLL/SRL
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse; result outputs are valid in that cycle
//   ALUResult    registered result
//   Zero         registered (ALUResult == 0)
//   invalid_op   registered; high when the completed opcode was 9-15
module sequential_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ALUOperation,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        invalid_op
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_NOR = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_LUI = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_CMP = 4'd8
  } op_t;

  state_t      r_state;
  logic        r_shift_left;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_invalid;

  logic [31:0] w_imm_result;
  logic        w_imm_invalid;
  logic        w_is_shift;
  logic [31:0] w_work_next;

  // Result of a single-cycle operation, computed straight from the inputs
  // on the accepting edge. Shift opcodes here cover the shamt=0 case only.
  always_comb begin
    w_imm_result  = '0;
    w_imm_invalid = 1'b0;
    case (ALUOperation)
      OP_AND:         w_imm_result = A & B;
      OP_OR:          w_imm_result = A | B;
      OP_NOR:         w_imm_result = ~(A | B);
      OP_ADD:         w_imm_result = A + B;
      OP_SUB, OP_CMP: w_imm_result = A - B;
      OP_LUI:         w_imm_result = {B[15:0], 16'h0000};
      OP_SLL, OP_SRL: w_imm_result = B;
      default: begin
        w_imm_result  = '0;
        w_imm_invalid = 1'b1;
      end
    endcase
  end

  assign w_is_shift  = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
  assign w_work_next = r_shift_left ? {r_work[30:0], 1'b0} : {1'b0, r_work[31:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shift_left <= 1'b0;
      r_work       <= '0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_invalid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift_left <= (ALUOperation == OP_SLL);
            if (w_is_shift && (shamt != 5'd0)) begin
              r_work  <= B;
              r_cnt   <= shamt;
              r_state <= S_SHIFT;
            end else begin
              r_result  <= w_imm_result;
              r_zero    <= (w_imm_result == '0);
              r_invalid <= w_imm_invalid;
              r_state   <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt - 5'd1;
          // Last shift step: publish the shifted value as it is written.
          if (r_cnt == 5'd1) begin
            r_result  <= w_work_next;
            r_zero    <= (w_work_next == '0);
            r_invalid <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign ALUResult  = r_result;
  assign Zero       = r_zero;
  assign invalid_op = r_invalid;

endmodule

// File: doc/sequential_alu.md
SEQUENTIAL_ALU -- requirements
Module: sequential_alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with no asynchronous reset path.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 start  input  1  request pulse; accepted only on an edge where busy=0.
REQ-005 ALUOperation  input  4  operation code: 0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB, 5 LUI, 6 SLL, 7 SRL, 8 compare; 9-15 invalid.
REQ-006 A  input  32  operand A (rs).
REQ-007 B  input  32  operand B (rt/immediate).
REQ-008 shamt  input  5  shift amount for SLL/SRL.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; ALUResult, Zero and invalid_op are valid in that cycle.
REQ-011 ALUResult  output  32  registered result.
REQ-012 Zero  output  1  registered; equals (ALUResult == 0), updated together with ALUResult.
REQ-013 invalid_op  output  1  registered; high if the completed operation code was 9-15.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 On an accepted start, the block SHALL latch ALUOperation, A, B and shamt; later input changes SHALL NOT affect the operation in flight.
REQ-016 While busy=1, start SHALL be ignored. Busy includes the DONE cycle, so back-to-back operations are at least 2 cycles apart.
REQ-017 Non-shift opcodes (0-5, 8-15) SHALL go IDLE->DONE on the accepting edge, so done is high in the cycle after acceptance (latency 1).
REQ-018 SLL/SRL with shamt=0 SHALL go IDLE->DONE with ALUResult=B (latency 1).
REQ-019 SLL/SRL with shamt=n>0 SHALL go IDLE->SHIFT and load B into a work register and n into a 5-bit counter.
REQ-020 In the SHIFT state, each edge SHALL shift the work register by one bit (left with 0 fill for SLL, logical right for SRL) and decrement the counter.
REQ-021 The shift SHALL go SHIFT->DONE on the edge where the counter goes from 1 to 0, so done rises n+1 cycles after acceptance (n=31 gives latency 32).
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-023 Results: AND A&B; OR A|B; NOR ~(A|B); ADD A+B; SUB A-B; LUI {B[15:0],16'h0000}; compare (8) A-B.
REQ-024 ADD, SUB and compare SHALL wrap modulo 2^32, with no overflow or carry output.
REQ-025 Invalid opcodes (9-15) SHALL produce ALUResult=0, Zero=1 and invalid_op=1. invalid_op SHALL be 0 for every valid opcode.
REQ-026 ALUResult, Zero and invalid_op SHALL update only on the edge entering DONE and SHALL hold until the next entry into DONE.

Reset
REQ-027 While reset=0 at a clk edge, the block SHALL set state=IDLE, busy=0, done=0, ALUResult=0, Zero=0, invalid_op=0, and clear the counter and work register.
REQ-028 Reset mid-SHIFT or during DONE SHALL abort the operation with no done pulse; results of the aborted operation SHALL NOT appear.
REQ-029 If reset=0 and start=1 on the same edge, reset SHALL win and the start SHALL be dropped.

Verification
REQ-030 ADD: A=32'hFFFF_FFFF, B=1, op=3, start for 1 cycle -> next cycle done=1, ALUResult=0, Zero=1, invalid_op=0.
REQ-031 Compare/NOR/LUI:
- op=8, A=B=32'h1234_5678 -> Zero=1 at done.
- op=2, A=0, B=0 -> ALUResult=32'hFFFF_FFFF.
- op=5, B=32'h0000_ABCD -> ALUResult=32'hABCD_0000.
REQ-032 SLL: B=32'h0000_0001, shamt=31, op=6 -> busy for 32 cycles, done exactly 32 cycles after acceptance, ALUResult=32'h8000_0000.
REQ-033 SRL: B=32'h8000_0000, shamt=4, op=7 -> done at cycle 5, ALUResult=32'h0800_0000. A start pulsed with op=3 during busy is ignored, and no second done follows.
REQ-034 Invalid opcode: op=4'hC -> done at latency 1, ALUResult=0, invalid_op=1. A following op=0 with A=B=32'hF0F0_F0F0 -> invalid_op=0, ALUResult=32'hF0F0_F0F0.
REQ-035 Reset abort: reset=0 applied on cycle 3 of an SLL with shamt=10 -> busy=0, done=0 and ALUResult=0 from the next cycle; no done pulse afterwards. A new ADD started after reset completes normally.
